adc_monitor: RTL and testbench

Parametrised ADC health monitor in the `adc_clk` domain, sitting between the ADC input pins and the rx/waterfall datapath. It generalises the single overflow detector and single level counter to a windowed overflow detector with a programmable count threshold and NLVL independent saturating level counters. It adds a peak-magnitude hold and a coherent snapshot so the CPU reads one consistent set of values. All configuration arrives already synchronised into `adc_clk`; CDC is the instantiating block's job.

---
 rtl/adc_monitor.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_adc_monitor.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_monitor.sv
// ---------------------------------------------------------------------------
// adc_monitor
//
// ADC health monitor living entirely in the adc_clk domain. It watches the
// raw ADC sample stream and keeps:
//   * a windowed overflow detector (2^WIN_BITS samples per window) that
//     pulses ovfl_A when the overflow count of a window reaches OVFL_THR,
//     and a sticky copy of that pulse;
//   * NLVL saturating level counters, each counting either overrange
//     samples or samples whose magnitude reaches a programmable level;
//   * a peak-magnitude hold;
//   * a snapshot bank so software reads one coherent set of values.
//
// Ports:
//   adc_clk      sample clock (only clock)
//   reset_n      asynchronous active-low reset
//   adc_data     signed ADC sample, one per cycle
//   adc_ovfl     ADC overrange flag belonging to adc_data
//   cfg_wr       single-cycle config write strobe
//   cfg_addr     config register address
//   cfg_data     config write data
//   snap         single-cycle snapshot request
//   rd_addr      snapshot register select
//   rd_data      selected snapshot value (registered, zero-extended)
//   snap_done    one-cycle pulse once the snapshot registers are loaded
//   ovfl_A       one-cycle pulse after a window that met the threshold
//   ovfl_sticky  latched OR of ovfl_A, cleared through CTRL bit1
//
// Config map: 0 = OVFL_THR, 1 = CTRL (bit0 clr counters, bit1 clr sticky,
// bit2 clr peak, bit3 restart window), 2..2+NLVL-1 = LVL_i.
// Read map:   0 = peak, 1 = last_win, 2 = win_ctr, 3..3+NLVL-1 = counter i.
// ---------------------------------------------------------------------------
module adc_monitor #(
    parameter int ADC_BITS = 14,
    parameter int NLVL     = 4,
    parameter int WIN_BITS = 16,
    parameter int CNT_W    = 32
) (
    input  logic                adc_clk,
    input  logic                reset_n,
    input  logic [ADC_BITS-1:0] adc_data,
    input  logic                adc_ovfl,
    input  logic                cfg_wr,
    input  logic [3:0]          cfg_addr,
    input  logic [31:0]         cfg_data,
    input  logic                snap,
    input  logic [3:0]          rd_addr,
    output logic [31:0]         rd_data,
    output logic                snap_done,
    output logic                ovfl_A,
    output logic                ovfl_sticky
);

    localparam int MAG_W = ADC_BITS - 1;
    // A full window can hold 2^WIN_BITS overflows, one more than WIN_BITS
    // bits can express, so the window total carries an extra bit.
    localparam int TOT_W = WIN_BITS + 1;

    // ------------------------------------------------------------------
    // Front end: magnitude and overflow flag registered together
    // ------------------------------------------------------------------
    logic [MAG_W-1:0] mag_next;
    logic [MAG_W-1:0] mag_reg;
    logic             ovfl_reg;

    // |x| for negative x only depends on the low MAG_W bits of x. The most
    // negative code has no positive twin and saturates to full scale.
    always_comb begin
        mag_next = adc_data[MAG_W-1:0];
        if (adc_data[ADC_BITS-1]) begin
            if (adc_data[MAG_W-1:0] == '0) begin
                mag_next = '1;
            end else begin
                mag_next = ~adc_data[MAG_W-1:0] + MAG_W'(1);
            end
        end
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            mag_reg  <= '0;
            ovfl_reg <= 1'b0;
        end else begin
            mag_reg  <= mag_next;
            ovfl_reg <= adc_ovfl;
        end
    end

    // ------------------------------------------------------------------
    // Config decode. CTRL has no storage: its bits act only in the cycle
    // of the write.
    // ------------------------------------------------------------------
    logic       ctrl_wr;
    logic [3:0] ctrl;
    logic       thr_wr;

    assign ctrl_wr = cfg_wr && (cfg_addr == 4'd1);
    assign ctrl    = ctrl_wr ? cfg_data[3:0] : 4'd0;
    assign thr_wr  = cfg_wr && (cfg_addr == 4'd0);

    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_data;

    logic [WIN_BITS-1:0] thr_reg;

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            thr_reg <= '0;
        end else if (thr_wr) begin
            thr_reg <= cfg_data[WIN_BITS-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Level counters with their snapshot copies
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] snap_cnt_arr [NLVL];

    genvar gi;
    generate
        for (gi = 0; gi < NLVL; gi++) begin : g_lvl
            logic [ADC_BITS-1:0] lvl_reg;
            logic [CNT_W-1:0]    cnt_reg;
            logic [CNT_W-1:0]    snap_cnt_reg;
            logic                lvl_wr;
            logic                hit;

            assign lvl_wr = cfg_wr && (cfg_addr == 4'(2 + gi));
            // Top bit of LVL selects overrange counting instead of a level.
            assign hit = lvl_reg[ADC_BITS-1] ? ovfl_reg
                                             : (mag_reg >= lvl_reg[MAG_W-1:0]);

            always_ff @(posedge adc_clk or negedge reset_n) begin
                if (!reset_n) begin
                    lvl_reg      <= '0;
                    cnt_reg      <= '0;
                    snap_cnt_reg <= '0;
                end else begin
                    if (lvl_wr) begin
                        lvl_reg <= cfg_data[ADC_BITS-1:0];
                    end
                    // A new level restarts its count; the clear beats any
                    // increment on the same edge.
                    if (lvl_wr || ctrl[0]) begin
                        cnt_reg <= '0;
                    end else if (hit && (cnt_reg != '1)) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                    if (snap) begin
                        snap_cnt_reg <= cnt_reg;
                    end
                end
            end

            assign snap_cnt_arr[gi] = snap_cnt_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Peak magnitude hold. A clear reloads from the sample in flight so no
    // sample is lost across the clear.
    // ------------------------------------------------------------------
    logic [MAG_W-1:0] peak_reg;

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_reg <= '0;
        end else if (ctrl[2] || (mag_reg > peak_reg)) begin
            peak_reg <= mag_reg;
        end
    end

    // ------------------------------------------------------------------
    // Overflow window
    // ------------------------------------------------------------------
    logic [WIN_BITS-1:0] win_ctr_reg;
    logic [WIN_BITS-1:0] win_cnt_reg;
    logic [TOT_W-1:0]    last_win_reg;
    logic [TOT_W-1:0]    win_total;
    logic                win_term;
    logic                ovfl_a_reg;
    logic                sticky_reg;

    assign win_term  = (win_ctr_reg == '1);
    // The terminal sample itself still belongs to the window.
    assign win_total = {1'b0, win_cnt_reg} + TOT_W'(ovfl_reg);

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            win_ctr_reg  <= '0;
            win_cnt_reg  <= '0;
            last_win_reg <= '0;
            ovfl_a_reg   <= 1'b0;
        end else if (win_term) begin
            last_win_reg <= win_total;
            win_ctr_reg  <= '0;
            win_cnt_reg  <= '0;
            ovfl_a_reg   <= (thr_reg != '0) && (win_total >= {1'b0, thr_reg});
        end else begin
            ovfl_a_reg <= 1'b0;
            if (ctrl[3]) begin
                win_ctr_reg <= '0;
                win_cnt_reg <= '0;
            end else begin
                win_ctr_reg <= win_ctr_reg + WIN_BITS'(1);
                if (ovfl_reg && (win_cnt_reg != '1)) begin
                    win_cnt_reg <= win_cnt_reg + WIN_BITS'(1);
                end
            end
        end
    end

    // Setting beats clearing so a pulse is never lost to a concurrent clear.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_reg <= 1'b0;
        end else if (ovfl_a_reg) begin
            sticky_reg <= 1'b1;
        end else if (ctrl[1]) begin
            sticky_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot bank and read port. The captures use pre-edge values so
    // clears/increments on the snap edge are not part of the snapshot.
    // ------------------------------------------------------------------
    logic [MAG_W-1:0]    snap_peak_reg;
    logic [TOT_W-1:0]    snap_last_reg;
    logic [WIN_BITS-1:0] snap_ctr_reg;
    logic                snap_done_reg;
    logic [31:0]         rd_next;
    logic [31:0]         rd_data_reg;

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_peak_reg <= '0;
            snap_last_reg <= '0;
            snap_ctr_reg  <= '0;
            snap_done_reg <= 1'b0;
        end else begin
            snap_done_reg <= snap;
            if (snap) begin
                snap_peak_reg <= peak_reg;
                snap_last_reg <= last_win_reg;
                snap_ctr_reg  <= win_ctr_reg;
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (rd_addr)
            4'd0:    rd_next = 32'(snap_peak_reg);
            4'd1:    rd_next = 32'(snap_last_reg);
            4'd2:    rd_next = 32'(snap_ctr_reg);
            default: begin
                for (int i = 0; i < NLVL; i++) begin
                    if (rd_addr == 4'(3 + i)) begin
                        rd_next = 32'(snap_cnt_arr[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= rd_next;
        end
    end

    assign rd_data     = rd_data_reg;
    assign snap_done   = snap_done_reg;
    assign ovfl_A      = ovfl_a_reg;
    assign ovfl_sticky = sticky_reg;

endmodule

// File: tb/tb_adc_monitor.sv
// ---------------------------------------------------------------------------
// tb_adc_monitor
//
// Self-checking bench for adc_monitor (ADC_BITS=14, NLVL=4, WIN_BITS=4,
// CNT_W=8). A cycle-level behavioural model built from plain integer
// arithmetic tracks what every output must be; one compare process checks
// rd_data, snap_done, ovfl_A and ovfl_sticky after every clock edge, and a
// set of directed scenarios pins hand-computed values.
// ---------------------------------------------------------------------------
module tb_adc_monitor;

    localparam int ADC_BITS = 14;
    localparam int NLVL     = 4;
    localparam int WIN_BITS = 4;
    localparam int CNT_W    = 8;
    localparam int WIN_LEN  = 1 << WIN_BITS;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int MAG_MAX  = (1 << (ADC_BITS - 1)) - 1;

    logic                adc_clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [ADC_BITS-1:0] adc_data = '0;
    logic                adc_ovfl = 1'b0;
    logic                cfg_wr = 1'b0;
    logic [3:0]          cfg_addr = '0;
    logic [31:0]         cfg_data = '0;
    logic                snap = 1'b0;
    logic [3:0]          rd_addr = '0;
    logic [31:0]         rd_data;
    logic                snap_done;
    logic                ovfl_A;
    logic                ovfl_sticky;

    adc_monitor #(
        .ADC_BITS(ADC_BITS),
        .NLVL    (NLVL),
        .WIN_BITS(WIN_BITS),
        .CNT_W   (CNT_W)
    ) dut (
        .adc_clk    (adc_clk),
        .reset_n    (reset_n),
        .adc_data   (adc_data),
        .adc_ovfl   (adc_ovfl),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .snap       (snap),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .snap_done  (snap_done),
        .ovfl_A     (ovfl_A),
        .ovfl_sticky(ovfl_sticky)
    );

    always #5 adc_clk = ~adc_clk;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    task automatic check(input string name, input longint act, input longint exp, input bit verbose);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else if (verbose) begin
            $display("txn %s: got %0d, expected %0d ok", name, act, exp);
        end
    endtask

    task automatic lit(input string name, input longint act, input longint exp);
        check(name, act, exp, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: integer state describing the monitor after each
    // edge. m_mag/m_ovf is the sample captured at the previous edge.
    // ------------------------------------------------------------------
    int m_mag, m_ovf, m_peak, m_thr, m_pos, m_wovf, m_last;
    int m_pulse, m_sticky, m_done, m_rd;
    int m_lvl [NLVL];
    int m_cnt [NLVL];
    int s_peak, s_last, s_pos;
    int s_cnt [NLVL];

    function automatic int snap_val(input int a);
        if (a == 0) return s_peak;
        if (a == 1) return s_last;
        if (a == 2) return s_pos;
        if (a >= 3 && a < 3 + NLVL) return s_cnt[a - 3];
        return 0;
    endfunction

    task automatic model_reset();
        m_mag = 0; m_ovf = 0; m_peak = 0; m_thr = 0; m_pos = 0; m_wovf = 0;
        m_last = 0; m_pulse = 0; m_sticky = 0; m_done = 0; m_rd = 0;
        s_peak = 0; s_last = 0; s_pos = 0;
        for (int i = 0; i < NLVL; i++) begin
            m_lvl[i] = 0; m_cnt[i] = 0; s_cnt[i] = 0;
        end
    endtask

    task automatic model_step();
        int ctrl;
        int v;
        int total;
        ctrl = (cfg_wr && cfg_addr == 4'd1) ? int'(cfg_data[3:0]) : 0;

        m_rd   = snap_val(int'(rd_addr));
        m_done = int'(snap);
        if (snap) begin
            s_peak = m_peak; s_last = m_last; s_pos = m_pos;
            for (int i = 0; i < NLVL; i++) s_cnt[i] = m_cnt[i];
        end

        if (m_pulse != 0) m_sticky = 1;
        else if (ctrl[1]) m_sticky = 0;

        if (m_pos == WIN_LEN - 1) begin
            total   = m_wovf + m_ovf;
            m_pulse = (m_thr != 0 && total >= m_thr) ? 1 : 0;
            m_last  = total;
            m_pos   = 0;
            m_wovf  = 0;
        end else begin
            m_pulse = 0;
            if (ctrl[3]) begin
                m_pos = 0; m_wovf = 0;
            end else begin
                m_pos++;
                m_wovf = (m_wovf + m_ovf > WIN_LEN - 1) ? WIN_LEN - 1 : m_wovf + m_ovf;
            end
        end

        if (ctrl[2]) m_peak = m_mag;
        else if (m_mag > m_peak) m_peak = m_mag;

        for (int i = 0; i < NLVL; i++) begin
            bit hit;
            bit wr_i;
            hit  = (m_lvl[i] >= (1 << (ADC_BITS - 1))) ? (m_ovf != 0)
                                                       : (m_mag >= (m_lvl[i] % (1 << (ADC_BITS - 1))));
            wr_i = cfg_wr && (int'(cfg_addr) == 2 + i);
            if (wr_i || ctrl[0]) m_cnt[i] = 0;
            else if (hit && m_cnt[i] < CNT_MAX) m_cnt[i]++;
            if (wr_i) m_lvl[i] = int'(cfg_data) & ((1 << ADC_BITS) - 1);
        end
        if (cfg_wr && cfg_addr == 4'd0) m_thr = int'(cfg_data) & (WIN_LEN - 1);

        v     = int'($signed(adc_data));
        m_mag = (v < 0) ? -v : v;
        if (m_mag > MAG_MAX) m_mag = MAG_MAX;
        m_ovf = int'(adc_ovfl);
    endtask

    initial begin : model_proc
        model_reset();
        forever begin
            @(posedge adc_clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin : compare_proc
        forever begin
            @(posedge adc_clk);
            #1;
            if (reset_n) begin
                check("rd_data", rd_data, m_rd, 1'b0);
                check("snap_done", snap_done, m_done, 1'b0);
                check("ovfl_A", ovfl_A, m_pulse, 1'b0);
                check("ovfl_sticky", ovfl_sticky, m_sticky, 1'b0);
                if (ovfl_A) pulses++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change on the falling edge only.
    // ------------------------------------------------------------------
    task automatic drive(input int d, input bit o, input bit wr = 1'b0, input int addr = 0,
                         input int cd = 0, input bit sn = 1'b0, input int ra = 0);
        @(negedge adc_clk);
        adc_data = ADC_BITS'(d);
        adc_ovfl = o;
        cfg_wr   = wr;
        cfg_addr = 4'(addr);
        cfg_data = 32'(cd);
        snap     = sn;
        rd_addr  = 4'(ra);
    endtask

    task automatic wait_edge();
        @(posedge adc_clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 1'b0);
    endtask

    task automatic cfg(input int addr, input int cd);
        drive(0, 1'b0, 1'b1, addr, cd);
    endtask

    task automatic take_snap(input int ctrl_bits);
        drive(0, 1'b0, ctrl_bits != 0, 1, ctrl_bits, 1'b1, 0);
        wait_edge();
        lit("snap_done_pulse", snap_done, 1);
    endtask

    task automatic read_snap(input int addr, input string name, input int exp);
        drive(0, 1'b0, 1'b0, 0, 0, 1'b0, addr);
        wait_edge();
        lit(name, rd_data, exp);
    endtask

    initial begin : main
        int first;
        #1;
        lit("reset_rd_data", rd_data, 0);
        lit("reset_snap_done", snap_done, 0);
        lit("reset_ovfl_A", ovfl_A, 0);
        lit("reset_sticky", ovfl_sticky, 0);
        repeat (3) @(posedge adc_clk);
        @(negedge adc_clk);
        reset_n = 1'b1;

        // Level counting: one level counter and one overrange counter.
        cfg(2, 100);
        cfg(3, 32'h2000);
        repeat (10) drive(150, 1'b0);
        drive(-100, 1'b0);
        repeat (5) drive(-99, 1'b0);
        repeat (3) drive(0, 1'b1);
        idle(2);
        take_snap(0);
        read_snap(3, "lvl0_count", 11);
        read_snap(4, "lvl1_ovfl_count", 3);

        // Magnitude saturation and peak clear with a concurrent sample.
        cfg(1, 4);
        drive(-8192, 1'b0);
        idle(2);
        take_snap(0);
        read_snap(0, "peak_saturated", MAG_MAX);
        drive(5, 1'b0);
        cfg(1, 4);
        idle(2);
        take_snap(0);
        read_snap(0, "peak_after_clear", 5);

        // Overflow window: restart aligns sample 0, threshold 3.
        pulses = 0;
        for (int i = 0; i <= 40; i++) begin
            bit ov;
            ov = (i == 3 || i == 8 || i == 15 || i == 20 || i == 27);
            drive(0, ov, i < 2, (i == 0) ? 1 : 0, (i == 0) ? 8 : 3, i == 20, 1);
            wait_edge();
            if (i == 22) begin
                lit("last_win_first", rd_data, 3);
                lit("sticky_set", ovfl_sticky, 1);
            end
        end
        take_snap(0);
        read_snap(1, "last_win_second", 2);
        lit("window_pulses", pulses, 1);
        cfg(1, 2);
        wait_edge();
        lit("sticky_cleared", ovfl_sticky, 0);

        // Counter saturation with a count-everything level.
        cfg(2, 0);
        for (int i = 0; i < 300; i++) drive(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
        idle(1);
        take_snap(0);
        read_snap(3, "lvl0_saturated", CNT_MAX);

        // Coherent snapshot alongside a counter clear.
        take_snap(1);
        read_snap(3, "lvl0_pre_clear", CNT_MAX);
        read_snap(6, "lvl3_pre_clear", CNT_MAX);
        take_snap(0);
        read_snap(3, "lvl0_post_clear", 2);

        // Randomised traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            int d;
            int addr;
            int cd;
            d    = ($urandom_range(0, 99) < 3) ? -8192 : int'($urandom_range(0, 16383));
            addr = int'($urandom_range(0, 15));
            cd   = int'($urandom);
            if (addr == 0) cd = int'($urandom_range(0, 4));
            if (addr == 1) cd = int'($urandom_range(0, 15));
            drive(d, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, addr, cd,
                  $urandom_range(0, 15) == 0, int'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-window with live state.
        cfg(0, 1);
        repeat (20) drive(-8192, 1'b1);
        take_snap(0);
        read_snap(0, "peak_before_reset", MAG_MAX);
        lit("sticky_before_reset", ovfl_sticky, 1);
        @(negedge adc_clk);
        #2;
        reset_n = 1'b0;
        #1;
        lit("async_rd_data", rd_data, 0);
        lit("async_snap_done", snap_done, 0);
        lit("async_ovfl_A", ovfl_A, 0);
        lit("async_sticky", ovfl_sticky, 0);
        repeat (2) @(posedge adc_clk);
        @(negedge adc_clk);
        reset_n  = 1'b1;
        adc_data = '0;
        adc_ovfl = 1'b1;
        cfg_wr   = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = 32'd1;
        snap     = 1'b0;
        rd_addr  = 4'd0;
        first    = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) drive(0, 1'b1);
            wait_edge();
            if (ovfl_A && first == 0) first = k;
        end
        lit("first_window_after_reset", first, WIN_LEN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
